// File: rtl/riscv_alu_pkg.sv
// Shared constants for the multi-cycle RISC-V ALU: op codes, branch funct3 codes, FSM states.
// The multiplier path is present only when RISCV_MC_ALU_MUL_EN is defined.
package riscv_alu_pkg;

    localparam int unsigned ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_MUL   = 4'd10;
    localparam logic [ALU_OP_W-1:0] ALU_MULHU = 4'd11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/riscv_mc_alu_if.sv
// Request/response bundle between the EXECUTE stage (master) and riscv_mc_alu (slave).
interface riscv_mc_alu_if #(
    parameter int unsigned XLEN = 32
) ();

    logic                                in_valid;
    logic                                in_ready;
    logic [riscv_alu_pkg::ALU_OP_W-1:0]  op;
    logic [2:0]                          funct3;
    logic [XLEN-1:0]                     a;
    logic [XLEN-1:0]                     b;
    logic                                out_valid;
    logic [XLEN-1:0]                     result;
    logic                                cmp;
    logic                                illegal;

    modport master (
        output in_valid, op, funct3, a, b,
        input  in_ready, out_valid, result, cmp, illegal
    );

    modport slave (
        input  in_valid, op, funct3, a, b,
        output in_ready, out_valid, result, cmp, illegal
    );

endinterface

// File: rtl/riscv_seq_mul.sv
// Radix-2 shift-add unsigned multiplier: loads on start, then one partial product per cycle.
// `prod` is the accumulator's next value, so it carries the full product while `done` is high.
module riscv_seq_mul #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*XLEN-1:0] prod
);

    localparam int unsigned CW = $clog2(XLEN) + 1;

    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = {{XLEN{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CW'(XLEN);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            busy_d   = (cnt_q != CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CW'(1));
    assign prod = acc_d;

endmodule

// File: rtl/riscv_mc_alu.sv
// Handshaked multi-cycle RV32I ALU with branch compare and registered results.
// Define RISCV_MC_ALU_MUL_EN to add MUL/MULHU via riscv_seq_mul; otherwise ops 10/11 are illegal.
module riscv_mc_alu
    import riscv_alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input logic           clk,
    input logic           rst_n,
    riscv_mc_alu_if.slave bus
);

    alu_state_e      state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            cmp_q, cmp_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic            cmp_res;
    logic            lt_s, lt_u;
    logic [SHW-1:0]  shamt;
    logic            accept;

`ifdef RISCV_MC_ALU_MUL_EN
    logic              hi_sel_q, hi_sel_d;
    logic              cmp_pend_q, cmp_pend_d;
    logic              mul_start, mul_busy, mul_done, is_mul_op;
    logic [2*XLEN-1:0] mul_prod;

    assign is_mul_op = (bus.op == ALU_MUL) || (bus.op == ALU_MULHU);

    riscv_seq_mul #(
        .XLEN (XLEN)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (bus.a),
        .b     (bus.b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );
`endif

    assign shamt  = bus.b[SHW-1:0];
    assign lt_s   = $signed(bus.a) < $signed(bus.b);
    assign lt_u   = bus.a < bus.b;
    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (bus.op)
            ALU_ADD:  alu_res = bus.a + bus.b;
            ALU_SUB:  alu_res = bus.a - bus.b;
            ALU_AND:  alu_res = bus.a & bus.b;
            ALU_OR:   alu_res = bus.a | bus.b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            ALU_XOR:  alu_res = bus.a ^ bus.b;
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            ALU_SLL:  alu_res = bus.a << shamt;
            ALU_SRL:  alu_res = bus.a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(bus.a) >>> shamt);
            default:  alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        case (bus.funct3)
            F3_BEQ:  cmp_res = (bus.a == bus.b);
            F3_BNE:  cmp_res = (bus.a != bus.b);
            F3_BLT:  cmp_res = lt_s;
            F3_BGE:  cmp_res = !lt_s;
            F3_BLTU: cmp_res = lt_u;
            F3_BGEU: cmp_res = !lt_u;
            default: cmp_res = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        cmp_d       = cmp_q;
        illegal_d   = illegal_q;
`ifdef RISCV_MC_ALU_MUL_EN
        hi_sel_d    = hi_sel_q;
        cmp_pend_d  = cmp_pend_q;
        mul_start   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    in_ready_d = 1'b0;
`ifdef RISCV_MC_ALU_MUL_EN
                    // Compare result is parked so the visible cmp only changes on DONE.
                    if (is_mul_op) begin
                        state_d    = ST_MUL;
                        mul_start  = 1'b1;
                        hi_sel_d   = (bus.op == ALU_MULHU);
                        cmp_pend_d = cmp_res;
                    end else
`endif
                    begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        cmp_d       = cmp_res;
                        illegal_d   = alu_ill;
                    end
                end
            end
`ifdef RISCV_MC_ALU_MUL_EN
            ST_MUL: begin
                if (mul_done) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    result_d    = hi_sel_q ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
                    cmp_d       = cmp_pend_q;
                    illegal_d   = 1'b0;
                end else if (!mul_busy) begin
                    // Defensive: never strand the FSM if the multiplier is idle.
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cmp_q       <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef RISCV_MC_ALU_MUL_EN
            hi_sel_q    <= 1'b0;
            cmp_pend_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            cmp_q       <= cmp_d;
            illegal_q   <= illegal_d;
`ifdef RISCV_MC_ALU_MUL_EN
            hi_sel_q    <= hi_sel_d;
            cmp_pend_q  <= cmp_pend_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.cmp       = cmp_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_riscv_mc_alu.sv
// Self-checking bench for riscv_mc_alu (XLEN = 32): a cycle-level reference model plus
// directed vectors with literal expectations. Follows RISCV_MC_ALU_MUL_EN like the design.
module tb_riscv_mc_alu;
    import riscv_alu_pkg::*;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    riscv_mc_alu_if #(.XLEN(XLEN)) bus ();

    riscv_mc_alu #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference behaviour: what the op must return and how many extra cycles it spends.
    function automatic void model(input logic [3:0] op, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c, output logic il,
                                  output int lat);
        logic [63:0] p;
        logic [31:0] sa, sb;
        int s;
        p  = {32'd0, a} * {32'd0, b};
        s  = int'(b[4:0]);
        sa = a ^ 32'h8000_0000;
        sb = b ^ 32'h8000_0000;
        il = 1'b0;
        lat = 0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd5:  r = a ^ b;
            4'd6:  r = (a < b) ? 32'd1 : 32'd0;
            4'd7:  r = a << s;
            4'd8:  r = a >> s;
            4'd9:  r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
`ifdef RISCV_MC_ALU_MUL_EN
            4'd10: begin r = p[31:0];  lat = XLEN; end
            4'd11: begin r = p[63:32]; lat = XLEN; end
`endif
            default: begin r = 32'd0; il = 1'b1; end
        endcase
        case (f3)
            3'b000:  c = (a == b);
            3'b001:  c = (a != b);
            3'b100:  c = (sa < sb);
            3'b101:  c = !(sa < sb);
            3'b110:  c = (a < b);
            3'b111:  c = !(a < b);
            default: c = 1'b0;
        endcase
    endfunction

    int          edge_n = 0;
    bit          busy_m = 1'b0;
    bit          vld_m = 1'b0;
    int          due = 0;
    logic [31:0] pend_res, hold_res;
    logic        pend_cmp, hold_cmp, pend_ill, hold_ill;

    always @(posedge clk) begin : model_p
        bit ready_old;
        int lat;
        edge_n++;
        if (!rst_n) begin
            busy_m   = 1'b0;
            vld_m    = 1'b0;
            hold_res = 32'd0;
            hold_cmp = 1'b0;
            hold_ill = 1'b0;
        end else begin
            ready_old = !busy_m;
            vld_m = 1'b0;
            if (busy_m && edge_n == due + 1) busy_m = 1'b0;
            if (ready_old && bus.in_valid === 1'b1) begin
                model(bus.op, bus.funct3, bus.a, bus.b, pend_res, pend_cmp, pend_ill, lat);
                busy_m = 1'b1;
                due = edge_n + lat;
            end
            if (busy_m && edge_n == due) begin
                vld_m    = 1'b1;
                hold_res = pend_res;
                hold_cmp = pend_cmp;
                hold_ill = pend_ill;
            end
        end
    end

    always @(negedge clk) begin
        if (edge_n > 0) begin
            check("m_in_ready", {31'd0, bus.in_ready}, {31'd0, !busy_m});
            check("m_out_valid", {31'd0, bus.out_valid}, {31'd0, vld_m});
            check("m_result", bus.result, hold_res);
            check("m_cmp", {31'd0, bus.cmp}, {31'd0, hold_cmp});
            check("m_illegal", {31'd0, bus.illegal}, {31'd0, hold_ill});
        end
    end

    // Present a request and return once it has been accepted (just after the accept edge).
    task automatic drive_accept(input logic [3:0] op, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b, output int e);
        int n;
        @(negedge clk);
        bus.op = op;
        bus.funct3 = f3;
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        e = edge_n;
    endtask

    // Drop in_valid and count cycles after accept until out_valid is seen.
    task automatic wait_done(output int lat);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ec, input logic ei, input int el);
        int e, lat;
        drive_accept(op, f3, a, b, e);
        wait_done(lat);
        check({name, "_lat"}, lat, el);
        check({name, "_res"}, bus.result, er);
        check({name, "_cmp"}, {31'd0, bus.cmp}, {31'd0, ec});
        check({name, "_ill"}, {31'd0, bus.illegal}, {31'd0, ei});
    endtask

    initial begin
        int e1, e2, lat, n;
        bit seen;
        bus.in_valid = 1'b0;
        bus.op = 4'd0;
        bus.funct3 = 3'd0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_result", bus.result, 32'd0);

        run_op("sra", ALU_SRA, 3'b000, 32'h8000_0010, 32'd4, 32'hF800_0001, 1'b0, 1'b0, 1);
        run_op("srl", ALU_SRL, 3'b000, 32'h8000_0010, 32'd4, 32'h0800_0001, 1'b0, 1'b0, 1);
        run_op("slt", ALU_SLT, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
        run_op("sltu", ALU_SLTU, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
        run_op("bge_eq", ALU_ADD, 3'b101, 32'd5, 32'd5, 32'd10, 1'b1, 1'b0, 1);
        run_op("sub_wrap", ALU_SUB, 3'b000, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
        run_op("f3_010", ALU_XOR, 3'b010, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0FF0_0FF0, 1'b0,
               1'b0, 1);
        run_op("sll31", ALU_SLL, 3'b001, 32'd1, 32'd31, 32'h8000_0000, 1'b1, 1'b0, 1);
        run_op("bltu", ALU_OR, 3'b110, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
        run_op("illegal13", 4'd13, 3'b000, 32'd7, 32'd7, 32'd0, 1'b1, 1'b1, 1);

        // Back-to-back single-cycle ops with in_valid held high.
        drive_accept(ALU_ADD, 3'b000, 32'd1, 32'd2, e1);
        drive_accept(ALU_AND, 3'b000, 32'hF0, 32'h3C, e2);
        check("b2b_gap", e2 - e1, 32'd2);
        wait_done(lat);
        check("b2b_res", bus.result, 32'h30);

`ifdef RISCV_MC_ALU_MUL_EN
        drive_accept(ALU_MUL, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e1);
        @(negedge clk);
        bus.op = ALU_MULHU;
        n = 1;
        seen = 1'b0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
                check("mul_lat", n, 32'd33);
                check("mul_lo", bus.result, 32'h0000_0001);
            end
            @(negedge clk);
            n++;
        end
        check("mul_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        e2 = edge_n;
        check("mul_issue_gap", e2 - e1, 32'd34);
        wait_done(lat);
        check("mulhu_lat", lat, 32'd33);
        check("mulhu_hi", bus.result, 32'hFFFF_FFFE);

        // Reset ten cycles into a multiply: no pulse, everything back to reset values.
        drive_accept(ALU_MUL, 3'b000, 32'd6, 32'd7, e1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 2; i <= 10; i++) begin
            check("abort_no_valid", {31'd0, bus.out_valid}, 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_result", bus.result, 32'd0);
`else
        run_op("mul_off", ALU_MUL, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 1);
        run_op("mulhu_off", ALU_MULHU, 3'b001, 32'd2, 32'd3, 32'd0, 1'b1, 1'b1, 1);
`endif
        run_op("add_after", ALU_ADD, 3'b000, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
